// File: rtl/xls_add_tree_pipe.sv
// Pipelined multi-operand signed adder tree with valid/ready flow control.
// Each tree level is a register stage; wrap or saturate is applied ahead of the last register.
module xls_add_tree_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter bit SAT    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_ovf
);

    localparam int LEVELS = $clog2(NUM_IN);
    localparam int S      = LEVELS + 1;
    localparam int FW     = WIDTH + LEVELS;

    // Number of live lanes held by tree stage k.
    function automatic int lanes_at(input int k);
        return (NUM_IN + (1 << k) - 1) >> k;
    endfunction

    // True when the full-precision sum is representable in WIDTH signed bits.
    function automatic logic fits_width(input logic signed [FW-1:0] v);
        return v[FW-1:WIDTH-1] == {(LEVELS+1){v[WIDTH-1]}};
    endfunction

    function automatic logic [WIDTH-1:0] sat_clamp(input logic signed [FW-1:0] v);
        if (fits_width(v)) begin
            return v[WIDTH-1:0];
        end else if (v[FW-1]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    logic [S-1:0]         r_vld;
    logic [S-1:0]         w_en;
    logic signed [FW-1:0] r_lane [LEVELS][NUM_IN];
    logic signed [FW-1:0] w_nxt  [LEVELS][NUM_IN];
    logic signed [FW-1:0] w_full;
    logic [WIDTH-1:0]     w_res;
    logic                 w_ovf;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_ovf;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        w_en = '0;
        for (int k = 0; k < S; k++) begin
            w_en[k] = out_ready;
            for (int j = k; j < S; j++) begin
                if (!r_vld[j]) begin
                    w_en[k] = 1'b1;
                end
            end
        end
    end

    // Stage 0 input: sign-extend every lane to full tree precision.
    for (genvar j = 0; j < NUM_IN; j++) begin : g_in
        assign w_nxt[0][j] = {{LEVELS{in_data[j*WIDTH+WIDTH-1]}}, in_data[j*WIDTH +: WIDTH]};
    end

    // Stages 1..LEVELS-1: pairwise sums, odd trailing lane forwarded unchanged.
    for (genvar k = 1; k < LEVELS; k++) begin : g_lvl
        localparam int NP = lanes_at(k - 1);
        for (genvar j = 0; j < NUM_IN; j++) begin : g_lane
            if (2*j + 1 < NP) begin : g_add
                assign w_nxt[k][j] = r_lane[k-1][2*j] + r_lane[k-1][2*j+1];
            end else if (2*j + 1 == NP) begin : g_pass
                assign w_nxt[k][j] = r_lane[k-1][2*j];
            end else begin : g_zero
                assign w_nxt[k][j] = '0;
            end
        end
    end

    // Final stage input: last pair sum, then wrap or clamp to WIDTH bits.
    assign w_full = r_lane[LEVELS-1][0] + r_lane[LEVELS-1][1];
    assign w_ovf  = !fits_width(w_full);
    assign w_res  = SAT ? sat_clamp(w_full) : w_full[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld      <= '0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            for (int k = 0; k < LEVELS; k++) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    r_lane[k][j] <= '0;
                end
            end
        end else begin
            if (w_en[0]) begin
                r_vld[0] <= in_valid;
            end
            for (int k = 1; k < S; k++) begin
                if (w_en[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
            for (int k = 0; k < LEVELS; k++) begin
                if (w_en[k]) begin
                    for (int j = 0; j < NUM_IN; j++) begin
                        r_lane[k][j] <= w_nxt[k][j];
                    end
                end
            end
            if (w_en[S-1]) begin
                r_out_data <= w_res;
                r_out_ovf  <= w_ovf;
            end
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = r_vld[S-1];
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_xls_add_tree_pipe.sv
// Scoreboard bench for xls_add_tree_pipe: default config, 8-bit wrap/saturate pair, 5-lane 16-bit stream.
module tb_xls_add_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, out_ovf0;
    logic [95:0] in_data0;
    logic [31:0] out_data0;

    logic        in_valid8, in_ready8w, in_ready8s, out_valid8w, out_valid8s, out_ready8;
    logic        out_ovf8w, out_ovf8s;
    logic [31:0] in_data8;
    logic [7:0]  out_data8w, out_data8s;

    logic        in_valid5, in_ready5, out_valid5, out_ready5, out_ovf5;
    logic [79:0] in_data5;
    logic [15:0] out_data5;

    xls_add_tree_pipe #(.WIDTH(32), .NUM_IN(3), .SAT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ovf(out_ovf0));

    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(4), .SAT(1'b0)) dut8w (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8w), .in_data(in_data8),
        .out_valid(out_valid8w), .out_ready(out_ready8), .out_data(out_data8w), .out_ovf(out_ovf8w));

    xls_add_tree_pipe #(.WIDTH(8), .NUM_IN(4), .SAT(1'b1)) dut8s (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8s), .in_data(in_data8),
        .out_valid(out_valid8s), .out_ready(out_ready8), .out_data(out_data8s), .out_ovf(out_ovf8s));

    xls_add_tree_pipe #(.WIDTH(16), .NUM_IN(5), .SAT(1'b0)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_ovf(out_ovf5));

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        o;
    } exp_t;

    exp_t q0[$];
    exp_t q8w[$];
    exp_t q8s[$];
    exp_t q5[$];

    // Signed sum of n lanes of width w packed in d.
    function automatic longint sum_lanes(input logic [127:0] d, input int w, input int n);
        longint s;
        longint t;
        s = 0;
        for (int i = 0; i < n; i++) begin
            t = longint'(d[i*w +: 64]);
            t = (t <<< (64 - w)) >>> (64 - w);
            s += t;
        end
        return s;
    endfunction

    function automatic exp_t ref_model(input longint s, input int w, input bit sat);
        exp_t   e;
        longint mx;
        longint mn;
        longint r;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -mx - 1;
        e.o = (s > mx) || (s < mn);
        r   = s;
        if (sat && s > mx) r = mx;
        if (sat && s < mn) r = mn;
        e.d = 64'(r) & ((64'd1 << w) - 64'd1);
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid0); else n_pass++;
        n_total++;
        if (out_data0 !== 32'd0 || out_ovf0 !== 1'b0)
            $display("FAIL reset_out_data got=%h/%b exp=0/0", out_data0, out_ovf0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if (in_ready0 !== 1'b1 || in_ready8w !== 1'b1 || in_ready5 !== 1'b1)
            $display("FAIL reset_in_ready got=%b%b%b exp=111", in_ready0, in_ready8w, in_ready5);
        else n_pass++;
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat;
        lat = -1;
        @(negedge clk);
        in_data0   = {32'd11, 32'd7, 32'd5};
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        #1;
        n_total++;
        if (in_ready0 !== 1'b1) $display("FAIL basic_accept got=%b exp=1", in_ready0); else n_pass++;
        q0.push_back(ref_model(sum_lanes({32'b0, in_data0}, 32, 3), 32, 1'b0));
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            #1;
            if (out_valid0) begin
                if (lat < 0) lat = c;
                n_total++;
                if (q0.size() == 0) begin
                    $display("FAIL basic_extra got=%h exp=none", out_data0);
                end else begin
                    e = q0.pop_front();
                    if (out_data0 !== 32'd23 || out_ovf0 !== 1'b0 || e.d[31:0] !== 32'd23)
                        $display("FAIL basic_sum got=%0d/%b exp=23/0", out_data0, out_ovf0);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat); else n_pass++;
        n_total++;
        if (q0.size() != 0) $display("FAIL basic_drain got=%0d left exp=0", q0.size()); else n_pass++;
    endtask

    task automatic test_sat8();
        logic [31:0] vec [6];
        int   idx;
        int   got;
        exp_t e;
        vec[0] = 32'h0000_017F;
        vec[1] = 32'h0000_FF80;
        vec[2] = 32'h0000_0080;
        vec[3] = 32'h7F7F_7F7F;
        vec[4] = 32'h03FB_140A;
        vec[5] = 32'h8080_8080;
        idx = 0;
        got = 0;
        out_ready8 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            in_valid8 = (idx < 6);
            in_data8  = (idx < 6) ? vec[idx] : 32'd0;
            #1;
            if (out_valid8w) begin
                got++;
                n_total++;
                if (q8w.size() == 0) begin
                    $display("FAIL sat8_wrap_extra got=%h exp=none", out_data8w);
                end else begin
                    e = q8w.pop_front();
                    if (out_data8w !== e.d[7:0] || out_ovf8w !== e.o)
                        $display("FAIL sat8_wrap got=%h/%b exp=%h/%b", out_data8w, out_ovf8w, e.d[7:0], e.o);
                    else n_pass++;
                end
            end
            if (out_valid8s) begin
                n_total++;
                if (q8s.size() == 0) begin
                    $display("FAIL sat8_sat_extra got=%h exp=none", out_data8s);
                end else begin
                    e = q8s.pop_front();
                    if (out_data8s !== e.d[7:0] || out_ovf8s !== e.o)
                        $display("FAIL sat8_sat got=%h/%b exp=%h/%b", out_data8s, out_ovf8s, e.d[7:0], e.o);
                    else n_pass++;
                end
            end
            if (in_valid8 && in_ready8w) begin
                q8w.push_back(ref_model(sum_lanes({96'b0, in_data8}, 8, 4), 8, 1'b0));
                q8s.push_back(ref_model(sum_lanes({96'b0, in_data8}, 8, 4), 8, 1'b1));
                idx++;
            end
        end
        in_valid8 = 1'b0;
        n_total++;
        if (got != 6 || q8w.size() != 0 || q8s.size() != 0)
            $display("FAIL sat8_count got=%0d exp=6", got);
        else n_pass++;
    endtask

    task automatic test_stream5();
        int   idx;
        int   got;
        int   first_c;
        int   last_c;
        exp_t e;
        idx = 0;
        got = 0;
        first_c = -1;
        last_c = -1;
        out_ready5 = 1'b1;
        for (int c = 0; c < 115; c++) begin
            @(negedge clk);
            in_valid5 = (idx < 100);
            in_data5  = {16'($urandom()), $urandom(), $urandom()};
            #1;
            if (out_valid5) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
                n_total++;
                if (q5.size() == 0) begin
                    $display("FAIL stream5_extra got=%h exp=none", out_data5);
                end else begin
                    e = q5.pop_front();
                    if (out_data5 !== e.d[15:0] || out_ovf5 !== e.o)
                        $display("FAIL stream5_data got=%h/%b exp=%h/%b", out_data5, out_ovf5, e.d[15:0], e.o);
                    else n_pass++;
                end
            end
            if (in_valid5 && in_ready5) begin
                q5.push_back(ref_model(sum_lanes({48'b0, in_data5}, 16, 5), 16, 1'b0));
                idx++;
            end
        end
        in_valid5 = 1'b0;
        n_total++;
        if (first_c != 4) $display("FAIL stream5_latency got=%0d exp=4", first_c); else n_pass++;
        n_total++;
        if (got != 100 || last_c != 103)
            $display("FAIL stream5_rate got=%0d items last=%0d exp=100 last=103", got, last_c);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          acc;
        int          drained;
        exp_t        first;
        exp_t        e;
        logic [95:0] nv;
        acc = 0;
        drained = 0;
        out_ready0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid0 = 1'b1;
            in_data0  = {$urandom(), $urandom(), $urandom()};
            #1;
            if (!in_ready0) break;
            q0.push_back(ref_model(sum_lanes({32'b0, in_data0}, 32, 3), 32, 1'b0));
            acc++;
        end
        n_total++;
        if (acc != 3) $display("FAIL bp_accepted got=%0d exp=3", acc); else n_pass++;
        first = q0[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (out_valid0 !== 1'b1 || out_data0 !== first.d[31:0] || out_ovf0 !== first.o || in_ready0 !== 1'b0)
                $display("FAIL bp_hold got=%b %h/%b rdy=%b exp=1 %h/%b rdy=0",
                         out_valid0, out_data0, out_ovf0, in_ready0, first.d[31:0], first.o);
            else n_pass++;
        end
        // Full pipeline: drain one and accept one on the same edge.
        @(negedge clk);
        nv = {32'd300, 32'hFFFF_FFFF, 32'd5};
        in_data0   = nv;
        in_valid0  = 1'b1;
        out_ready0 = 1'b1;
        #1;
        n_total++;
        if (in_ready0 !== 1'b1) $display("FAIL bp_swap_ready got=%b exp=1", in_ready0); else n_pass++;
        e = q0.pop_front();
        n_total++;
        if (out_valid0 !== 1'b1 || out_data0 !== e.d[31:0] || out_ovf0 !== e.o)
            $display("FAIL bp_swap_out got=%b %h exp=1 %h", out_valid0, out_data0, e.d[31:0]);
        else n_pass++;
        q0.push_back(ref_model(sum_lanes({32'b0, nv}, 32, 3), 32, 1'b0));
        @(negedge clk);
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        #1;
        n_total++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1)
            $display("FAIL bp_still_full got=rdy%b vld%b exp=rdy0 vld1", in_ready0, out_valid0);
        else n_pass++;
        out_ready0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid0) begin
                drained++;
                n_total++;
                if (q0.size() == 0) begin
                    $display("FAIL bp_extra got=%h exp=none", out_data0);
                end else begin
                    e = q0.pop_front();
                    if (out_data0 !== e.d[31:0] || out_ovf0 !== e.o)
                        $display("FAIL bp_drain got=%h/%b exp=%h/%b", out_data0, out_ovf0, e.d[31:0], e.o);
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        n_total++;
        if (drained != 3 || q0.size() != 0) $display("FAIL bp_drain_count got=%0d exp=3", drained); else n_pass++;
    endtask

    task automatic test_random();
        int   sent;
        int   recv;
        exp_t e;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            in_valid0  = (sent < 1000) && 1'($urandom_range(0, 1));
            in_data0   = {$urandom(), $urandom(), $urandom()};
            out_ready0 = 1'($urandom_range(0, 1));
            #1;
            if (out_valid0 && out_ready0) begin
                recv++;
                n_total++;
                if (q0.size() == 0) begin
                    $display("FAIL rand_extra got=%h exp=none", out_data0);
                end else begin
                    e = q0.pop_front();
                    if (out_data0 !== e.d[31:0] || out_ovf0 !== e.o)
                        $display("FAIL rand_data got=%h/%b exp=%h/%b", out_data0, out_ovf0, e.d[31:0], e.o);
                    else n_pass++;
                end
            end
            if (in_valid0 && in_ready0) begin
                q0.push_back(ref_model(sum_lanes({32'b0, in_data0}, 32, 3), 32, 1'b0));
                sent++;
            end
            if (sent == 1000 && recv == 1000) break;
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        n_total++;
        if (recv != 1000 || q0.size() != 0)
            $display("FAIL rand_count got=%0d left=%0d exp=1000 left=0", recv, q0.size());
        else n_pass++;
        repeat (4) @(negedge clk);
        #1;
        n_total++;
        if (out_valid0 !== 1'b0) $display("FAIL rand_idle got=%b exp=0", out_valid0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        out_ready0 = 1'b0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_data0  = {32'd0, 32'd1, 32'h7FFF_FFFF};
        @(negedge clk);
        in_data0  = {32'd9, 32'd8, 32'd7};
        @(negedge clk);
        in_valid0 = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if (out_valid0 !== 1'b1 || out_data0 !== 32'h8000_0000 || out_ovf0 !== 1'b1)
            $display("FAIL mid_pre got=%b %h/%b exp=1 80000000/1", out_valid0, out_data0, out_ovf0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid0 !== 1'b0 || out_data0 !== 32'd0 || out_ovf0 !== 1'b0)
            $display("FAIL mid_reset got=%b %h/%b exp=0 0/0", out_valid0, out_data0, out_ovf0);
        else n_pass++;
        @(negedge clk);
        rst        = 1'b0;
        out_ready0 = 1'b1;
        in_valid0  = 1'b1;
        in_data0   = {32'd3, 32'd2, 32'd1};
        #1;
        n_total++;
        if (in_ready0 !== 1'b1) $display("FAIL mid_ready got=%b exp=1", in_ready0); else n_pass++;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid0 = 1'b0;
            #1;
            n_total++;
            if (c == 3) begin
                if (out_valid0 !== 1'b1 || out_data0 !== 32'd6 || out_ovf0 !== 1'b0)
                    $display("FAIL mid_result got=%b %0d/%b exp=1 6/0", out_valid0, out_data0, out_ovf0);
                else n_pass++;
            end else begin
                if (out_valid0 !== 1'b0) $display("FAIL mid_stale cycle=%0d got=%b exp=0", c, out_valid0);
                else n_pass++;
            end
        end
    endtask

    initial begin
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;
        test_reset();
        test_basic();
        test_sat8();
        test_stream5();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xls_add_tree_pipe.md
# xls_add_tree_pipe

Parametrised, pipelined multi-operand adder with a valid/ready handshake. It sums NUM_IN lanes of WIDTH bits through a registered binary adder tree, with an optional signed-saturating output mode and an overflow flag. It is the general successor to the team's fixed 3×32-bit pipelined adder: width, operand count and overflow mode are configurable, and backpressure is supported. It sits between XLS-generated datapath stages wherever a streaming reduction sum is needed.

## Interface
- WIDTH, 32: operand and result width in bits (legal range 2..64).
- NUM_IN, 3: number of operand lanes (legal range 2..16).
- SAT, 0: 0 selects wrap mode (result mod 2^WIDTH); 1 selects signed-saturating mode.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept the operand vector this cycle.
- in_data  in  NUM_IN*WIDTH  packed operands; lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result this cycle.
- out_data  out  WIDTH  sum of all lanes.
- out_ovf  out  1  overflow indicator, qualified by out_valid.

## Operation
- LEVELS = ceil(log2(NUM_IN)). The pipeline has S = LEVELS+1 register stages.
- Stage 0 registers the NUM_IN input lanes.
- Stage k (1..LEVELS) registers the sums of adjacent pairs from stage k-1, pairing lanes (0,1), (2,3) and so on. An odd trailing lane passes through unchanged to the next level.
- Internal sums are sign-extended by one bit per level, so full precision is WIDTH+LEVELS bits and no internal overflow is possible.
- Final result, applied combinationally before the last register:
  - SAT=0: out_data = low WIDTH bits of the full sum. out_ovf = 1 when the signed full sum does not fit in WIDTH signed bits.
  - SAT=1: out_data = full sum clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_ovf = 1 when clamping occurred.
- Operands are always interpreted as two's-complement signed values. In wrap mode out_data is identical for unsigned interpretation.
- Handshake flow control (bubble-collapsing):
  - Each stage k holds its own valid bit v[k].
  - en[S-1] = !v[S-1] | out_ready.
  - en[k] = !v[k] | en[k+1].
  - in_ready = en[0].
  - When en[k] is high, stage k loads the data and valid of the stage before it. For stage 0 that is in_data and in_valid.
  - in_ready depends combinationally on out_ready; there is no combinational path from in_valid to out_valid.
- A transfer occurs on any edge where valid & ready are both high, on either port.
- While out_valid=1 and out_ready=0, out_data and out_ovf must hold stable. Bubbles behind the stalled result continue to advance and fill until v[0..S-1] are all set. At that point in_ready=0.
- Results leave in the same order the operands were accepted; nothing is dropped or duplicated.

## Timing
- Latency is S cycles from input transfer to out_valid with no stalls. Default config (NUM_IN=3): S=3.
- Throughput is one result per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous-safe deassert): all v[k]=0, all data registers =0, out_valid=0, out_data=0, out_ovf=0, and in_ready=1 on the first cycle after reset.
- Reset mid-stream discards every in-flight item; no partial result may appear afterward.
- If a result drains and a new operand vector is accepted on the same edge with the pipeline full, both happen; occupancy stays full and in_ready stays high.

## Test plan
- Defaults, lanes {5, 7, 11}, out_ready=1 → out_valid rises 3 cycles after transfer with out_data=23, out_ovf=0.
- WIDTH=8, NUM_IN=4, SAT=0, lanes {0x7F, 0x01, 0x00, 0x00} → out_data=0x80, out_ovf=1. Same config with SAT=1 → out_data=0x7F, out_ovf=1. Lanes {0x80, 0xFF, 0, 0} with SAT=1 → 0x80, out_ovf=1.
- NUM_IN=5, WIDTH=16, stream 100 random vectors with out_ready held at 1 → latency 4, one result per cycle, and every result matches the reference model including out_ovf.
- Hold out_ready=0 while feeding back-to-back vectors → in_ready falls after exactly S accepted items and out_data stays stable. Release out_ready → all S results emerge in order with no loss.
- Random in_valid/out_ready toggling (50% each) over 1000 items → scoreboard shows in-order, exact results with no duplicates.
- Assert rst for 1 cycle while 2 items are in flight → out_valid=0 and out_data=0 immediately. Next input {1, 2, 3} → output 6 after 3 cycles, with no stale results emitted.
